// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the fetch and load/store ports, the arbiter and the byte-wide RAM.
// The arbiter uses the slave view; the requesters and the RAM use the master view.
interface mem_arbiter_if;
   logic        in_rdy;
   logic        in_flush_enable;
   logic        in_io_buffer_full;

   logic        in_pc_requesting;
   logic [31:0] in_pc_addr;
   logic        out_pc_req_enable;
   logic        out_pc_data_enable;
   logic [31:0] out_pc_inst;

   logic        in_ls_requesting;
   logic        in_ls_write;
   logic [1:0]  in_ls_size;
   logic [31:0] in_ls_addr;
   logic [31:0] in_ls_wdata;
   logic        out_ls_req_enable;
   logic        out_ls_data_enable;
   logic [31:0] out_ls_rdata;

   logic [7:0]  in_mem_din;
   logic [7:0]  out_mem_dout;
   logic [31:0] out_mem_a;
   logic        out_mem_wr;

   modport slave (
      input  in_rdy, in_flush_enable, in_io_buffer_full,
      input  in_pc_requesting, in_pc_addr,
      output out_pc_req_enable, out_pc_data_enable, out_pc_inst,
      input  in_ls_requesting, in_ls_write, in_ls_size, in_ls_addr, in_ls_wdata,
      output out_ls_req_enable, out_ls_data_enable, out_ls_rdata,
      input  in_mem_din,
      output out_mem_dout, out_mem_a, out_mem_wr
   );

   modport master (
      output in_rdy, in_flush_enable, in_io_buffer_full,
      output in_pc_requesting, in_pc_addr,
      input  out_pc_req_enable, out_pc_data_enable, out_pc_inst,
      output in_ls_requesting, in_ls_write, in_ls_size, in_ls_addr, in_ls_wdata,
      input  out_ls_req_enable, out_ls_data_enable, out_ls_rdata,
      output in_mem_din,
      input  out_mem_dout, out_mem_a, out_mem_wr
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and the load/store buffer,
// serialising 1/2/4-byte accesses into byte cycles and reassembling reads little-endian.
module mem_arbiter #(
   parameter logic [1:0] IO_SEL = 2'b11
) (
   input logic          in_clk,
   input logic          in_rst,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

   state_t      state_reg, state_next;
   logic [2:0]  k_reg, k_next;
   logic [2:0]  n_reg, n_next;
   logic [31:0] addr_reg, addr_next;
   logic [31:0] wdata_reg, wdata_next;
   logic [31:0] data_reg, data_next;
   logic [31:0] mem_a_reg, mem_a_next;
   logic [7:0]  mem_dout_reg, mem_dout_next;
   logic        mem_wr_reg, mem_wr_next;
   logic        pc_de_reg, pc_de_next;
   logic        ls_de_reg, ls_de_next;
   logic [31:0] pc_inst_reg, pc_inst_next;
   logic [31:0] ls_rdata_reg, ls_rdata_next;
   logic        pc_req_en_reg, pc_req_en_next;
   logic        ls_req_en_reg, ls_req_en_next;

   logic [2:0]  k_plus;
   logic [31:0] byte_addr;
   logic [31:0] next_addr;
   logic [31:0] merged_word;
   logic [7:0]  store_byte;
   logic        store_stall;
   logic        accept_stall;
   logic        pc_valid;
   logic        ls_valid;
   logic        ls_take;
   logic        pc_take;

   function automatic logic [2:0] size_to_n(input logic [1:0] size);
      case (size)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   assign k_plus    = k_reg + 3'd1;
   assign byte_addr = addr_reg + {29'd0, k_reg};
   assign next_addr = addr_reg + {29'd0, k_plus};
   assign store_byte = wdata_reg[{k_reg[1:0], 3'b000} +: 8];

   assign store_stall  = (addr_reg[17:16] == IO_SEL) && bus.in_io_buffer_full;
   assign accept_stall = (bus.in_ls_addr[17:16] == IO_SEL) && bus.in_io_buffer_full;

   // A flush blocks speculative reads from being accepted but never a committed store.
   assign pc_valid = bus.in_pc_requesting && pc_req_en_reg;
   assign ls_valid = bus.in_ls_requesting && ls_req_en_reg;
   assign ls_take  = ls_valid && (bus.in_ls_write || !bus.in_flush_enable);
   assign pc_take  = pc_valid && !ls_valid && !bus.in_flush_enable;

   // Byte lane k takes the incoming RAM byte; the other lanes keep what was already captured.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[gi*8 +: 8] = (k_reg[1:0] == 2'(gi)) ? bus.in_mem_din : data_reg[gi*8 +: 8];
   end

   always_comb begin
      state_next     = state_reg;
      k_next         = k_reg;
      n_next         = n_reg;
      addr_next      = addr_reg;
      wdata_next     = wdata_reg;
      data_next      = data_reg;
      mem_a_next     = mem_a_reg;
      mem_dout_next  = mem_dout_reg;
      mem_wr_next    = mem_wr_reg;
      pc_de_next     = 1'b0;
      ls_de_next     = 1'b0;
      pc_inst_next   = pc_inst_reg;
      ls_rdata_next  = ls_rdata_reg;
      pc_req_en_next = pc_req_en_reg;
      ls_req_en_next = ls_req_en_reg;

      if (bus.in_rdy) begin
         case (state_reg)
            IDLE: begin
               mem_wr_next = 1'b0;
               k_next      = 3'd0;
               if (ls_take) begin
                  addr_next      = bus.in_ls_addr;
                  wdata_next     = bus.in_ls_wdata;
                  n_next         = size_to_n(bus.in_ls_size);
                  data_next      = 32'd0;
                  mem_a_next     = bus.in_ls_addr;
                  pc_req_en_next = 1'b0;
                  ls_req_en_next = 1'b0;
                  if (bus.in_ls_write) begin
                     state_next = STORE;
                     if (!accept_stall) begin
                        mem_dout_next = bus.in_ls_wdata[7:0];
                        mem_wr_next   = 1'b1;
                        k_next        = 3'd1;
                     end
                  end else begin
                     state_next = LOAD;
                  end
               end else if (pc_take) begin
                  state_next     = FETCH;
                  addr_next      = bus.in_pc_addr;
                  n_next         = 3'd4;
                  data_next      = 32'd0;
                  mem_a_next     = bus.in_pc_addr;
                  pc_req_en_next = 1'b0;
                  ls_req_en_next = 1'b0;
               end else begin
                  // Re-enable lands one edge after the completion pulse.
                  pc_req_en_next = 1'b1;
                  ls_req_en_next = 1'b1;
               end
            end

            FETCH, LOAD: begin
               if (bus.in_flush_enable) begin
                  state_next = IDLE;
                  mem_a_next = 32'd0;
                  k_next     = 3'd0;
               end else begin
                  data_next = merged_word;
                  if (k_plus == n_reg) begin
                     state_next = IDLE;
                     mem_a_next = 32'd0;
                     k_next     = 3'd0;
                     if (state_reg == FETCH) begin
                        pc_de_next   = 1'b1;
                        pc_inst_next = merged_word;
                     end else begin
                        ls_de_next    = 1'b1;
                        ls_rdata_next = merged_word;
                     end
                  end else begin
                     mem_a_next = next_addr;
                     k_next     = k_plus;
                  end
               end
            end

            STORE: begin
               if (k_reg == n_reg) begin
                  state_next  = IDLE;
                  mem_wr_next = 1'b0;
                  mem_a_next  = 32'd0;
                  k_next      = 3'd0;
                  ls_de_next  = 1'b1;
               end else if (store_stall) begin
                  mem_wr_next = 1'b0;
               end else begin
                  mem_a_next    = byte_addr;
                  mem_dout_next = store_byte;
                  mem_wr_next   = 1'b1;
                  k_next        = k_plus;
               end
            end

            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state_reg     <= IDLE;
         k_reg         <= 3'd0;
         n_reg         <= 3'd0;
         addr_reg      <= 32'd0;
         wdata_reg     <= 32'd0;
         data_reg      <= 32'd0;
         mem_a_reg     <= 32'd0;
         mem_dout_reg  <= 8'd0;
         mem_wr_reg    <= 1'b0;
         pc_de_reg     <= 1'b0;
         ls_de_reg     <= 1'b0;
         pc_inst_reg   <= 32'd0;
         ls_rdata_reg  <= 32'd0;
         pc_req_en_reg <= 1'b1;
         ls_req_en_reg <= 1'b1;
      end else begin
         state_reg     <= state_next;
         k_reg         <= k_next;
         n_reg         <= n_next;
         addr_reg      <= addr_next;
         wdata_reg     <= wdata_next;
         data_reg      <= data_next;
         mem_a_reg     <= mem_a_next;
         mem_dout_reg  <= mem_dout_next;
         mem_wr_reg    <= mem_wr_next;
         pc_de_reg     <= pc_de_next;
         ls_de_reg     <= ls_de_next;
         pc_inst_reg   <= pc_inst_next;
         ls_rdata_reg  <= ls_rdata_next;
         pc_req_en_reg <= pc_req_en_next;
         ls_req_en_reg <= ls_req_en_next;
      end
   end

   // A frozen cycle must never write, even with a byte held on the bus.
   assign bus.out_mem_wr         = mem_wr_reg && bus.in_rdy;
   assign bus.out_mem_a          = mem_a_reg;
   assign bus.out_mem_dout       = mem_dout_reg;
   assign bus.out_pc_req_enable  = pc_req_en_reg;
   assign bus.out_pc_data_enable = pc_de_reg;
   assign bus.out_pc_inst        = pc_inst_reg;
   assign bus.out_ls_req_enable  = ls_req_en_reg;
   assign bus.out_ls_data_enable = ls_de_reg;
   assign bus.out_ls_rdata       = ls_rdata_reg;
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the single byte-wide RAM port and shares it between two requesters: the instruction fetcher (fetch port) and the load/store buffer (LS port).
- Grants one request at a time and splits each 1/2/4-byte access into byte cycles.
- Reassembles read bytes little-endian and returns one pulse-qualified word.
- Stalls writes to the IO window while the UART buffer is full, and discards speculative reads on flush.

Parameters:
- IO_SEL, 2'b11: value of addr[17:16] that selects the IO window.

Ports:
- in_clk  input  1  clock; the only clock.
- in_rst  input  1  reset; synchronous, active-high.
- in_rdy  input  1  global enable; low = freeze.
- in_flush_enable  input  1  misprediction flush.
- in_io_buffer_full  input  1  UART output buffer full.
- in_pc_requesting  input  1  fetch request.
- in_pc_addr  input  32  fetch address.
- out_pc_req_enable  output  1  fetch port may issue.
- out_pc_data_enable  output  1  1-cycle pulse: out_pc_inst valid.
- out_pc_inst  output  32  fetched instruction.
- in_ls_requesting  input  1  LS request.
- in_ls_write  input  1  1 = store, 0 = load.
- in_ls_size  input  2  00 = 1B, 01 = 2B, 10 = 4B, 11 treated as 4B.
- in_ls_addr  input  32  LS address.
- in_ls_wdata  input  32  store data; low bytes used.
- out_ls_req_enable  output  1  LS port may issue.
- out_ls_data_enable  output  1  1-cycle pulse: load data valid or store complete.
- out_ls_rdata  output  32  load data, zero-extended.
- in_mem_din  input  8  RAM read byte; valid 1 cycle after its address.
- out_mem_dout  output  8  RAM write byte.
- out_mem_a  output  32  RAM address.
- out_mem_wr  output  1  RAM write strobe.

Behaviour:
- Reset sampled at posedge in_clk:
  - state IDLE, byte count 0.
  - out_mem_wr 0, out_mem_a 0, out_mem_dout 0.
  - both data_enable 0; out_pc_inst and out_ls_rdata 0.
  - both req_enable 1.
  - Reset overrides everything, including an access in flight; the partial access is dropped with no pulse.
- in_rdy low: all registers hold and out_mem_wr is gated to 0. Data pulses are not extended.
- States: IDLE, FETCH, LOAD, STORE. A 3-bit byte counter k runs 0..n, where n = 1, 2 or 4.
- Accept rule, in IDLE at an edge:
  - Both requesting and both req_enable high → LS wins (committed stores must not starve).
  - Otherwise the single valid requester wins.
  - On accept: latch addr, size and wdata; drop that port's req_enable and the other port's req_enable until the access completes.
- Reads (FETCH n = 4, LOAD n per size):
  - Accept edge E0: out_mem_a <= addr, k <= 0.
  - Edge Ej, j = 1..n: capture in_mem_din into byte j-1. For j < n, out_mem_a <= addr + j (mod 2^32).
  - At En: pulse the port's data_enable for exactly 1 cycle with the assembled word; state <= IDLE; out_mem_a <= 0.
  - Latency: the pulse is visible n cycles after the accept edge.
- Store:
  - Edge Ej, j = 0..n-1: out_mem_a <= addr + j, out_mem_dout <= wdata byte j, out_mem_wr <= 1.
  - Edge En: out_mem_wr <= 0, out_ls_data_enable pulse.
  - IO stall: if addr[17:16] == IO_SEL and in_io_buffer_full is high at a byte edge, that byte is not issued and j does not advance (out_mem_wr <= 0). It is retried each edge until the buffer is not full.
- Re-enable: both req_enable return to 1 on the edge after the data_enable pulse. A requester must drop requesting, or present a new address, by the edge at which it samples its data_enable. A requesting level seen with req_enable high is always a new request.
- Flush:
  - FETCH or LOAD in flight → abort: state IDLE, out_mem_a 0, no pulse, req_enables 1 next edge.
  - STORE in flight continues to completion.
  - In the flush cycle, fetch and load requests are not accepted; a store request is accepted.
  - A flush coinciding with the completing edge suppresses the read pulse.
- Load data is zero-extended above byte n-1; the LS buffer performs sign extension.

Test Plan:
- Fetch: RAM[0x100..0x103] = 13,05,10,00; fetch 0x100 → addresses 0x100..0x103 on consecutive cycles; out_pc_data_enable pulses 4 cycles after accept with out_pc_inst = 0x00100513; req_enable high again the next cycle.
- Simultaneous requests: fetch 0x0 and 4B load 0x200 in the same IDLE cycle → load served first (rdata = RAM word), then fetch accepted only after re-enable; never two accesses overlapping on out_mem_a.
- IO store with stall: SB to 0x30000, wdata 0x41, io_buffer_full high for 3 cycles → out_mem_wr stays 0 for those 3 cycles, then one write of 0x41 to 0x30000, then the done pulse.
- Address wrap: fetch 0xFFFFFFFE → addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001; word assembled little-endian.
- Flush mid-fetch at k = 2 → no out_pc_data_enable, IDLE next cycle. Flush mid 4B store at byte 1 → bytes 1..3 still written, pulse asserted.
- Reset mid-load: in_rst at k = 1 of LH → all outputs at reset values next cycle, no pulse, both req_enable = 1.
